// File: rtl/string_to_board_if.sv
// Character-stream and committed-board bundle for string_to_board.
// master: the character source that also observes the result.
// slave:  the parser itself.
interface string_to_board_if;
  logic         start;
  logic [7:0]   char_in;
  logic         char_valid;
  logic [319:0] board;
  logic [20:0]  score;
  logic         busy;
  logic         done;
  logic         error;

  modport master (
    output start, char_in, char_valid,
    input  board, score, busy, done, error
  );

  modport slave (
    input  start, char_in, char_valid,
    output board, score, busy, done, error
  );
endinterface

// File: rtl/string_to_board.sv
// string_to_board: parses 17 decimal fields (16 tiles, then the score) from an
// ASCII stream into the packed board/score format used by the board printer.
// Optional feature macro: STRING_TO_BOARD_POW2_CHECK_EN rejects tiles that are
// nonzero and not a power of two greater than one.
module string_to_board (
  input  logic              clk,
  input  logic              rst,
  string_to_board_if.slave  bus
);

`ifdef STRING_TO_BOARD_POW2_CHECK_EN
  localparam bit POW2_CHECK = 1'b1;
`else
  localparam bit POW2_CHECK = 1'b0;
`endif

  localparam logic [25:0] TILE_MAX  = 26'd1048575;
  localparam logic [25:0] SCORE_MAX = 26'd2097151;

  typedef enum logic [2:0] {IDLE, SKIP, NUM, DONE, ERR} state_t;

  state_t        state, state_nxt;
  logic [21:0]   acc;
  logic [4:0]    idx;
  logic [319:0]  work_board;
  logic [319:0]  board_q;
  logic [20:0]   score_q;
  logic          error_q;

  logic          ld_acc, mac_acc, wr_tile, commit, set_err;
  logic [3:0]    digit;
  logic [25:0]   mac;
  logic          tile_bad;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  function automatic logic is_sep(input logic [7:0] c);
    return (c == 8'h20) || (c == 8'h2C) || (c == 8'h7C) ||
           (c == 8'h0D) || (c == 8'h0A);
  endfunction

  // acc*10 + d, widened so the product can never wrap back under a limit.
  function automatic logic [25:0] mac10(input logic [21:0] a, input logic [3:0] d);
    return ({4'd0, a} << 3) + ({4'd0, a} << 1) + {22'd0, d};
  endfunction

  function automatic logic over_limit(input logic [25:0] v, input logic is_score);
    return is_score ? (v > SCORE_MAX) : (v > TILE_MAX);
  endfunction

  // A tile is a legal power-of-two value when it is 0 or 2^k with k >= 1.
  function automatic logic pow2_bad(input logic [21:0] v);
    return (v != 22'd0) && ((v == 22'd1) || ((v & (v - 22'd1)) != 22'd0));
  endfunction

  assign digit    = bus.char_in[3:0];
  assign mac      = mac10(acc, digit);
  assign tile_bad = POW2_CHECK && pow2_bad(acc);

  // Next-state and per-character actions; start overrides everything.
  always_comb begin
    state_nxt = state;
    ld_acc    = 1'b0;
    mac_acc   = 1'b0;
    wr_tile   = 1'b0;
    commit    = 1'b0;
    set_err   = 1'b0;
    if (bus.start) begin
      state_nxt = SKIP;
    end else begin
      case (state)
        IDLE: state_nxt = IDLE;
        SKIP: begin
          if (bus.char_valid) begin
            if (is_digit(bus.char_in)) begin
              ld_acc    = 1'b1;
              state_nxt = NUM;
            end else if (!is_sep(bus.char_in)) begin
              set_err   = 1'b1;
              state_nxt = ERR;
            end
          end
        end
        NUM: begin
          if (bus.char_valid) begin
            if (is_digit(bus.char_in)) begin
              if (over_limit(mac, idx[4])) begin
                set_err   = 1'b1;
                state_nxt = ERR;
              end else begin
                mac_acc = 1'b1;
              end
            end else if (is_sep(bus.char_in)) begin
              if (idx[4]) begin
                commit    = 1'b1;
                state_nxt = DONE;
              end else if (tile_bad) begin
                set_err   = 1'b1;
                state_nxt = ERR;
              end else begin
                wr_tile   = 1'b1;
                state_nxt = SKIP;
              end
            end else begin
              set_err   = 1'b1;
              state_nxt = ERR;
            end
          end
        end
        DONE:    state_nxt = IDLE;
        ERR:     state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Committed outputs and sticky error; commit happens as DONE is entered so
  // board/score change in the same cycle done is seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      board_q <= '0;
      score_q <= '0;
      error_q <= 1'b0;
    end else begin
      if (commit) begin
        board_q <= work_board;
        score_q <= acc[20:0];
      end
      if (bus.start)    error_q <= 1'b0;
      else if (set_err) error_q <= 1'b1;
    end
  end

  // Working accumulator, field index and tile buffer.
  always_ff @(posedge clk) begin
    if (bus.start) begin
      acc        <= '0;
      idx        <= '0;
      work_board <= '0;
    end else begin
      if (ld_acc)  acc <= {18'd0, digit};
      if (mac_acc) acc <= mac[21:0];
      if (wr_tile) begin
        for (int i = 0; i < 16; i++) begin
          if (idx[3:0] == 4'(i)) work_board[319 - 20*i -: 20] <= acc[19:0];
        end
        idx <= idx + 5'd1;
      end
    end
  end

  assign bus.board = board_q;
  assign bus.score = score_q;
  assign bus.error = error_q;
  assign bus.busy  = (state == SKIP) || (state == NUM);
  assign bus.done  = (state == DONE);

endmodule

// File: tb/tb_string_to_board.sv
// Randomized self-checking bench for string_to_board: streams of decimal fields
// with random separators, leading zeros and idle gaps, checked against a
// field-level model of the parse result.
module tb_string_to_board;

`ifdef STRING_TO_BOARD_POW2_CHECK_EN
  localparam bit POW2_EN = 1'b1;
`else
  localparam bit POW2_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  string_to_board_if bus ();

  string_to_board dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int           vectors     = 0;
  int           miscompares = 0;
  int           done_cnt    = 0;
  bit           gaps        = 1'b0;
  bit           noisy       = 1'b0;
  int unsigned  fv [17];
  logic [319:0] exp_board   = '0;
  logic [20:0]  exp_score   = '0;
  logic [7:0]   seps [5]    = '{8'h20, 8'h2C, 8'h7C, 8'h0D, 8'h0A};

  always @(negedge clk) if (bus.done) done_cnt++;

  task automatic chk(input string tag, input logic [319:0] got, input logic [319:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rand_sep();
    return seps[$urandom_range(0, 4)];
  endfunction

  function automatic bit pow2_bad(input int unsigned v);
    return POW2_EN && (v != 0) && ((v == 1) || ((v & (v - 1)) != 0));
  endfunction

  function automatic logic [319:0] pack();
    logic [319:0] b;
    b = '0;
    for (int i = 0; i < 16; i++) b[319 - 20*i -: 20] = fv[i][19:0];
    return b;
  endfunction

  task automatic send_char(input logic [7:0] c);
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        bus.char_in    = 8'($urandom);
        bus.char_valid = 1'b0;
        tick();
      end
    end
    bus.char_in    = c;
    bus.char_valid = 1'b1;
    tick();
    bus.char_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int k = 0; k < s.len(); k++) send_char(s[k]);
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic after_abort();
    tick();
    chk("abort_no_done", done_cnt, 0);
    chk("abort_board_kept", bus.board, exp_board);
    chk("abort_score_kept", bus.score, exp_score);
  endtask

  task automatic check_commit();
    chk("done_pulse", bus.done, 1);
    exp_board = pack();
    exp_score = fv[16][20:0];
    chk("board", bus.board, exp_board);
    chk("score", bus.score, exp_score);
    chk("no_error", bus.error, 0);
    tick();
    chk("done_once", done_cnt, 1);
    chk("idle_busy", bus.busy, 0);
  endtask

  // Emits fv[] as a stream and checks the outcome the field values imply.
  task automatic run_fields(input bit do_st);
    longint     prefix, limit;
    string      s;
    logic [7:0] c;
    done_cnt = 0;
    if (do_st) begin
      do_start();
      chk("start_busy", bus.busy, 1);
      chk("start_err_clr", bus.error, 0);
    end
    for (int f = 0; f < 17; f++) begin
      limit = (f < 16) ? 64'd1048575 : 64'd2097151;
      if (noisy) repeat ($urandom_range(0, 2)) send_char(rand_sep());
      if (noisy) repeat ($urandom_range(0, 2)) send_char(8'h30);
      s = $sformatf("%0d", fv[f]);
      prefix = 0;
      for (int k = 0; k < s.len(); k++) begin
        c = s[k];
        send_char(c);
        prefix = prefix * 10 + longint'(c - 8'h30);
        if (prefix > limit) begin
          chk("ovf_error", bus.error, 1);
          chk("ovf_busy", bus.busy, 0);
          after_abort();
          return;
        end
      end
      send_char(rand_sep());
      if (f < 16 && pow2_bad(fv[f])) begin
        chk("pow2_error", bus.error, 1);
        chk("pow2_busy", bus.busy, 0);
        after_abort();
        return;
      end
    end
    check_commit();
  endtask

  task automatic set_basic();
    foreach (fv[i]) fv[i] = 0;
    fv[0] = 2; fv[3] = 4; fv[5] = 8; fv[10] = 16; fv[15] = 2048; fv[16] = 102444;
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.char_in = 8'h00;
    bus.char_valid = 1'b0;
    tick();
    tick();
    chk("rst_board", bus.board, 0);
    chk("rst_score", bus.score, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_error", bus.error, 0);
    rst = 1'b0;
    tick();

    // Basic parse, exact text
    set_basic();
    do_start();
    done_cnt = 0;
    send_str("2 0 0 4\n0 8 0 0\n0 0 16 0\n0 0 0 2048\n102444\n");
    check_commit();

    // Separator runs and leading zeros
    set_basic();
    fv[1] = 4;
    do_start();
    done_cnt = 0;
    send_str("  |002|,,4 0 4\r\n0 8 0 0\n0 0 16 0\n0 0 0 2048\n102444\n");
    check_commit();

    // Tile overflow and the largest legal tile
    foreach (fv[i]) fv[i] = 0;
    fv[16] = 5;
    fv[3] = 1048576;
    run_fields(1'b1);
    fv[3] = 1048575;
    run_fields(1'b1);
    fv[3] = 0;
    fv[16] = 2097152;
    run_fields(1'b1);
    fv[16] = 2097151;
    run_fields(1'b1);

    // Illegal character in field 5, then recovery
    do_start();
    done_cnt = 0;
    send_str("2 2 2 2 2 x");
    chk("illegal_error", bus.error, 1);
    chk("illegal_busy", bus.busy, 0);
    after_abort();
    set_basic();
    run_fields(1'b1);

    // start with a valid char: char dropped, parse restarts from tile 0
    do_start();
    send_str("2 4 1");
    bus.start = 1'b1;
    bus.char_in = 8'h37;
    bus.char_valid = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.char_valid = 1'b0;
    chk("restart_busy", bus.busy, 1);
    set_basic();
    fv[0] = 8;
    run_fields(1'b0);

    // Reset mid-parse clears committed outputs
    do_start();
    send_str("4 4 1");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_board", bus.board, 0);
    chk("midrst_score", bus.score, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_done", bus.done, 0);
    chk("midrst_error", bus.error, 0);
    exp_board = '0;
    exp_score = '0;

    // Power-of-two rule: tiles 6 and 1
    foreach (fv[i]) fv[i] = 0;
    fv[2] = 6;
    fv[16] = 77;
    run_fields(1'b1);
    fv[2] = 0;
    fv[7] = 1;
    run_fields(1'b1);

    // Randomized streams
    for (int t = 0; t < 40; t++) begin
      gaps  = 1'($urandom_range(0, 1));
      noisy = 1'b1;
      for (int i = 0; i < 16; i++) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3: fv[i] = 0;
          9:          fv[i] = $urandom_range(0, 1048575);
          default:    fv[i] = 32'd1 << $urandom_range(1, 19);
        endcase
      end
      fv[16] = $urandom_range(0, 2097151);
      if ($urandom_range(0, 7) == 0) fv[$urandom_range(0, 15)] = 1048576 + $urandom_range(0, 3000000);
      if ($urandom_range(0, 9) == 0) fv[16] = 2097152 + $urandom_range(0, 3000000);
      run_fields(1'b1);
    end

    // Stream ending without a separator stays busy
    gaps = 1'b0;
    do_start();
    done_cnt = 0;
    send_str("16 32");
    repeat (3) tick();
    chk("unterminated_busy", bus.busy, 1);
    chk("unterminated_no_done", done_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
